// File: rtl/mul_product_drain.sv
// Buffers full-width multiplier products in a 2-deep FIFO and drains each one
// onto a half-width bus as a LO word followed by a HI word.
module mul_product_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [2*DATA_WIDTH-1:0] in_product,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [DATA_WIDTH-1:0]   hi_reg,
  output logic [DATA_WIDTH-1:0]   lo_reg,
  output logic [CNT_WIDTH-1:0]    done_count
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

  logic [PW-1:0]         mem_reg [0:1];
  logic [1:0]            count_reg, count_next;
  logic                  rd_ptr_reg, rd_ptr_next;
  logic                  wr_ptr_reg, wr_ptr_next;
  phase_t                phase_reg, phase_next;
  logic [DATA_WIDTH-1:0] hi_next, lo_next;
  logic [CNT_WIDTH-1:0]  done_next;
  logic [PW-1:0]         head;
  logic                  push, xfer, pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (phase_reg == PH_HI);
  assign head      = mem_reg[rd_ptr_reg];

  // Storage is left unreset; entries are only visible while count is non-zero.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= in_product;
        end
      end
    end
  endgenerate

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_last = (phase_reg == PH_HI);
      out_data = (phase_reg == PH_HI) ? head[PW-1:DATA_WIDTH] : head[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    phase_next  = phase_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = done_count;

    if (push) begin
      wr_ptr_next = ~wr_ptr_reg;
    end

    case (phase_reg)
      PH_LO: begin
        if (xfer) begin
          phase_next = PH_HI;
        end
      end
      PH_HI: begin
        if (xfer) begin
          phase_next  = PH_LO;
          rd_ptr_next = ~rd_ptr_reg;
          hi_next     = head[PW-1:DATA_WIDTH];
          lo_next     = head[DATA_WIDTH-1:0];
          done_next   = done_count + CNT_WIDTH'(1);
        end
      end
      default: phase_next = PH_LO;
    endcase

    // Concurrent push and pop leave occupancy untouched.
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !push) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      phase_reg  <= PH_LO;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_count <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      phase_reg  <= phase_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_count <= done_next;
    end
  end

endmodule
